packet_register_controller: RTL and testbench

- Parametrised successor to the single-purpose UART write controller.
- Parses framed byte packets from the UART receive stream (UART_PACKET from Structures) addressed to this block, and issues either a register write (address plus multi-byte data) or a register read request.
- Adds configurable address and data widths, a read opcode, packet-length checking, and an error pulse.
- Sits between the UART RX deframer and the register file.

---
 rtl/packet_register_controller_if.sv | 10 +
 rtl/packet_register_controller.sv | 104 ++++++++++
 tb/tb_packet_register_controller.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/packet_register_controller_if.sv
// packet_register_controller_if: UART RX deframer beat stream (Valid/SoP/EoP/Source/Data)
interface packet_register_controller_if;
  logic       Valid;
  logic       SoP;
  logic       EoP;
  logic [7:0] Source;
  logic [7:0] Data;
  modport master (output Valid, SoP, EoP, Source, Data);
  modport slave  (input  Valid, SoP, EoP, Source, Data);
endinterface

// File: rtl/packet_register_controller.sv
// packet_register_controller: parses framed UART packets into register write/read strobes
module packet_register_controller #(
  parameter logic [7:0] LOCAL_SOURCE = 8'h01,
  parameter int ADDR_BYTES = 1,
  parameter int DATA_BYTES = 4
) (
  input  logic                      ipClk,
  input  logic                      ipReset,
  packet_register_controller_if.slave ipRxStream,
  output logic                      opWrEnable,
  output logic                      opRdEnable,
  output logic [8*ADDR_BYTES-1:0]   opAddress,
  output logic [8*DATA_BYTES-1:0]   opWrData,
  output logic                      opError
);
  localparam int AW = 8*ADDR_BYTES;
  localparam int DW = 8*DATA_BYTES;
  localparam int MAXB = ADDR_BYTES > DATA_BYTES ? ADDR_BYTES : DATA_BYTES;
  localparam int CW = $clog2(MAXB+1);
  localparam logic [1:0] IDLE = 2'd0, GET_ADDR = 2'd1, GET_DATA = 2'd2, DISCARD = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic          isWrite;
  logic [AW-1:0] addrShift;
  logic [DW-1:0] dataShift;
  logic          beat, sop, eop, fromLocal, legal, lastAddr, lastData;
  logic [AW-1:0] addrNext;
  logic [DW-1:0] dataNext;

  assign beat      = ipRxStream.Valid;
  assign sop       = beat & ipRxStream.SoP;
  assign eop       = ipRxStream.EoP;
  assign fromLocal = ipRxStream.Source == LOCAL_SOURCE;
  assign legal     = ipRxStream.Data[7:1] == 7'd0;
  assign lastAddr  = count == CW'(ADDR_BYTES-1);
  assign lastData  = count == CW'(DATA_BYTES-1);
  assign addrNext  = AW'({addrShift, ipRxStream.Data});
  assign dataNext  = DW'({dataShift, ipRxStream.Data});

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      opWrEnable <= 1'b0;
      opRdEnable <= 1'b0;
      opError    <= 1'b0;
      opAddress  <= '0;
      opWrData   <= '0;
      state      <= IDLE;
      count      <= '0;
      isWrite    <= 1'b0;
      addrShift  <= '0;
      dataShift  <= '0;
    end else begin
      opWrEnable <= 1'b0;
      opRdEnable <= 1'b0;
      opError    <= 1'b0;
      // SoP always restarts parsing; an abort mid-packet shares the header's error pulse
      if (sop) begin
        opError <= state == GET_ADDR || state == GET_DATA || (fromLocal && (eop || !legal));
        count   <= '0;
        isWrite <= ipRxStream.Data[0];
        state   <= eop ? IDLE : (!fromLocal || !legal) ? DISCARD : GET_ADDR;
      end else if (beat) begin
        case (state)
          GET_ADDR: begin
            addrShift <= addrNext;
            count     <= count + CW'(1);
            if (lastAddr) begin
              if (!isWrite && eop) begin
                opAddress  <= addrNext;
                opRdEnable <= 1'b1;
                state      <= IDLE;
              end else if (!isWrite || eop) begin
                opError <= 1'b1;
                state   <= eop ? IDLE : DISCARD;
              end else begin
                count <= '0;
                state <= GET_DATA;
              end
            end else if (eop) begin
              opError <= 1'b1;
              state   <= IDLE;
            end
          end
          GET_DATA: begin
            dataShift <= dataNext;
            count     <= count + CW'(1);
            if (lastData && eop) begin
              opAddress  <= addrShift;
              opWrData   <= dataNext;
              opWrEnable <= 1'b1;
              state      <= IDLE;
            end else if (lastData || eop) begin
              opError <= 1'b1;
              state   <= eop ? IDLE : DISCARD;
            end
          end
          DISCARD: state <= eop ? IDLE : DISCARD;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_packet_register_controller.sv
// tb_packet_register_controller: random packet stream into two parameterisations vs packet-level model
module tb_packet_register_controller;
  logic ipClk = 1'b0;
  logic ipReset = 1'b1;
  always #5 ipClk = ~ipClk;

  packet_register_controller_if rx ();

  logic        wrA, rdA, errA, wrB, rdB, errB;
  logic [7:0]  addrA;
  logic [31:0] dataA;
  logic [15:0] addrB, dataB;

  packet_register_controller dutA (
    .ipClk(ipClk), .ipReset(ipReset), .ipRxStream(rx),
    .opWrEnable(wrA), .opRdEnable(rdA), .opAddress(addrA), .opWrData(dataA), .opError(errA));

  packet_register_controller #(.ADDR_BYTES(2), .DATA_BYTES(2)) dutB (
    .ipClk(ipClk), .ipReset(ipReset), .ipRxStream(rx),
    .opWrEnable(wrB), .opRdEnable(rdB), .opAddress(addrB), .opWrData(dataB), .opError(errB));

  typedef struct {
    int          kind;
    logic [63:0] addr;
    logic [63:0] data;
  } ev_t;

  int          passed = 0;
  int          total = 0;
  ev_t         q [2][$];
  logic [63:0] heldAddr [2];
  logic [63:0] heldData [2];
  logic [7:0]  pkt [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // A local packet yields exactly one event: its strobe if well formed, else one error
  function automatic ev_t model(input bit fromLocal, input bit eop, input int ab, input int db);
    ev_t e;
    int  len;
    e.kind = 0;
    e.addr = 0;
    e.data = 0;
    if (!fromLocal) return e;
    len = pkt[0] == 8'h01 ? 1 + ab + db : 1 + ab;
    if (pkt[0] > 8'h01 || !eop || pkt.size() != len) begin
      e.kind = 3;
      return e;
    end
    for (int i = 1; i <= ab; i++) e.addr = {e.addr[55:0], pkt[i]};
    for (int i = ab + 1; i < len; i++) e.data = {e.data[55:0], pkt[i]};
    e.kind = pkt[0] == 8'h01 ? 2 : 1;
    return e;
  endfunction

  task automatic pushModel(input logic [7:0] src, input bit eop);
    ev_t e;
    e = model(src == 8'h01, eop, 1, 4);
    if (e.kind != 0) q[0].push_back(e);
    e = model(src == 8'h01, eop, 2, 2);
    if (e.kind != 0) q[1].push_back(e);
  endtask

  task automatic drive(input bit v, input bit s, input bit e, input logic [7:0] src, input logic [7:0] d);
    rx.Valid = v;
    rx.SoP = s;
    rx.EoP = e;
    rx.Source = src;
    rx.Data = d;
    @(posedge ipClk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic sendPkt(input logic [7:0] src, input bit eop, input int gapMin, input int gapMax);
    pushModel(src, eop);
    foreach (pkt[i]) begin
      if (i > 0) repeat ($urandom_range(gapMin, gapMax)) idle();
      drive(1'b1, i == 0, eop && i == pkt.size() - 1, src, pkt[i]);
    end
  endtask

  task automatic setPkt(input logic [63:0] bytes, input int n);
    pkt.delete();
    for (int i = n - 1; i >= 0; i--) pkt.push_back(bytes[8*i +: 8]);
  endtask

  // Following an abort, the next header must not itself error, or the two pulses merge
  task automatic randPkt(input bit good, output bit aborted);
    int         len;
    logic [7:0] src;
    pkt.delete();
    src = (!good && $urandom_range(0, 7) == 0) ? 8'h02 : 8'h01;
    pkt.push_back((!good && $urandom_range(0, 9) == 0) ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, 1)));
    case ($urandom_range(0, 3))
      0: len = pkt[0] == 8'h01 ? 6 : 2;
      1: len = pkt[0] == 8'h01 ? 5 : 3;
      default: len = $urandom_range(good ? 2 : 1, 8);
    endcase
    for (int i = 1; i < len; i++) pkt.push_back(8'($urandom));
    aborted = !good && $urandom_range(0, 5) == 0;
    sendPkt(src, !aborted, 0, 2);
    if (!aborted) repeat ($urandom_range(0, 2)) drive(1'b1, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic observe(input int k, input logic wr, input logic rd, input logic er,
                         input logic [63:0] a, input logic [63:0] d);
    ev_t        e;
    logic [2:0] got;
    got = {wr, rd, er};
    if (got == 3'b000) return;
    if (q[k].size() == 0) begin
      check($sformatf("dut%0d spurious event", k), 64'(got), 64'd0);
      return;
    end
    e = q[k].pop_front();
    if (e.kind == 1) heldAddr[k] = e.addr;
    if (e.kind == 2) begin
      heldAddr[k] = e.addr;
      heldData[k] = e.data;
    end
    check($sformatf("dut%0d event kind", k), 64'(got),
          e.kind == 2 ? 64'b100 : e.kind == 1 ? 64'b010 : 64'b001);
    check($sformatf("dut%0d address", k), a, heldAddr[k]);
    check($sformatf("dut%0d wrdata", k), d, heldData[k]);
  endtask

  always @(negedge ipClk)
    if (!ipReset) begin
      observe(0, wrA, rdA, errA, 64'(addrA), 64'(dataA));
      observe(1, wrB, rdB, errB, 64'(addrB), 64'(dataB));
    end

  task automatic drain(input string tag);
    for (int i = 0; i < 50 && (q[0].size() + q[1].size()) != 0; i++) idle();
    idle();
    check(tag, 64'(q[0].size() + q[1].size()), 64'd0);
  endtask

  task automatic checkZero(input string tag);
    check({tag, " A"}, {wrA, rdA, errA, addrA, dataA}, 64'd0);
    check({tag, " B"}, {wrB, rdB, errB, addrB, dataB}, 64'd0);
  endtask

  initial begin
    bit ab, nb;
    heldAddr = '{64'd0, 64'd0};
    heldData = '{64'd0, 64'd0};
    rx.Valid = 0; rx.SoP = 0; rx.EoP = 0; rx.Source = 0; rx.Data = 0;
    repeat (3) idle();
    checkZero("reset");
    ipReset = 1'b0;
    idle();

    setPkt(64'h01_10_DEADBEEF, 6);
    sendPkt(8'h01, 1, 0, 0);
    check("write strobe", {wrA, rdA, errA}, 3'b100);
    check("write addr", 64'(addrA), 64'h10);
    check("write data", 64'(dataA), 64'hDEADBEEF);
    idle();
    check("write one cycle", 64'(wrA), 64'd0);

    setPkt(64'h00_3C, 2);
    sendPkt(8'h01, 1, 0, 0);
    check("read strobe", {wrA, rdA, errA}, 3'b010);
    check("read addr", 64'(addrA), 64'h3C);
    check("read keeps data", 64'(dataA), 64'hDEADBEEF);

    setPkt(64'h01_10_AA, 3);
    sendPkt(8'h01, 1, 0, 0);
    check("short write error", {wrA, rdA, errA}, 3'b001);
    check("short write addr held", 64'(addrA), 64'h3C);
    setPkt(64'h00_22, 2);
    sendPkt(8'h01, 1, 0, 0);
    check("read after error", {rdA, 8'(addrA)}, {1'b1, 8'h22});

    setPkt(64'h01_55_66778899, 6);
    sendPkt(8'h02, 1, 0, 0);
    check("foreign ignored", {wrA, rdA, errA, wrB, rdB, errB}, 6'd0);
    setPkt(64'h01_20_01020304, 6);
    sendPkt(8'h01, 1, 1, 1);
    check("stalled write", {wrA, 8'(addrA), dataA}, {1'b1, 8'h20, 32'h01020304});

    setPkt(64'h01_30_11_22, 4);
    sendPkt(8'h01, 0, 0, 0);
    setPkt(64'h00_44, 2);
    pushModel(8'h01, 1);
    drive(1'b1, 1'b1, 1'b0, 8'h01, 8'h00);
    check("abort error", {wrA, rdA, errA}, 3'b001);
    drive(1'b1, 1'b0, 1'b1, 8'h01, 8'h44);
    check("read after abort", {rdA, 8'(addrA)}, {1'b1, 8'h44});

    setPkt(64'h01_1234_ABCD, 5);
    sendPkt(8'h01, 1, 0, 0);
    check("wide write", {wrB, addrB, dataB}, {1'b1, 16'h1234, 16'hABCD});
    check("wide write on narrow dut", {wrA, errA}, 2'b01);

    ab = 0;
    repeat (300) begin
      randPkt(ab, nb);
      ab = nb;
    end
    if (ab) randPkt(1'b1, nb);
    drain("random drain");
    check("narrow addr held", 64'(addrA), heldAddr[0]);
    check("narrow data held", 64'(dataA), heldData[0]);
    check("wide addr held", 64'(addrB), heldAddr[1]);
    check("wide data held", 64'(dataB), heldData[1]);

    drive(1'b1, 1'b1, 1'b0, 8'h01, 8'h01);
    drive(1'b1, 1'b0, 1'b0, 8'h01, 8'h55);
    drive(1'b1, 1'b0, 1'b0, 8'h01, 8'h66);
    ipReset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 8'h01, 8'h77);
    checkZero("mid-packet reset");
    heldAddr = '{64'd0, 64'd0};
    heldData = '{64'd0, 64'd0};
    ipReset = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 8'h01, 8'h88);
    check("no strobe after reset", {wrA, rdA, errA, wrB, rdB, errB}, 6'd0);
    setPkt(64'h00_5A, 2);
    sendPkt(8'h01, 1, 0, 0);
    check("read after reset", {rdA, 8'(addrA), dataA}, {1'b1, 8'h5A, 32'h0});
    drain("final drain");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
